// File: rtl/rlwe_sched_pkg.sv
// Shared definitions for the RLWE processor-part scheduler: command
// opcodes, command field layout, FSM states and run kinds.
package rlwe_sched_pkg;

   typedef enum logic [2:0] {
      OP_NOP      = 3'b000,
      OP_LOAD     = 3'b001,
      OP_NTT      = 3'b010,
      OP_SWEEP    = 3'b011,
      OP_ADDCONV0 = 3'b100,
      OP_ADDCONV1 = 3'b101,
      OP_ILL0     = 3'b110,
      OP_ILL1     = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_RUN,
      ST_GAP
   } state_e;

   // Which sub-controller a launched command drives.
   typedef enum logic [1:0] {
      KIND_LD,
      KIND_NC,
      KIND_AC
   } kind_e;

   // Command byte layout: [7:5] opcode, [4] modulus_sel, [3:2] iter, [1:0] instr.
   typedef struct packed {
      opcode_e    opcode;
      logic       modulus_sel;
      logic [1:0] iter;
      logic [1:0] instr;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // Opcodes 11x have no meaning and are rejected.
   function automatic logic is_legal(opcode_e op);
      return !(op[2] && op[1]);
   endfunction

   function automatic kind_e kind_of(opcode_e op);
      case (op)
         OP_LOAD:           return KIND_LD;
         OP_NTT, OP_SWEEP:  return KIND_NC;
         default:           return KIND_AC;
      endcase
   endfunction

endpackage

// File: rtl/rlwe_cmd_fifo.sv
// Command FIFO for the scheduler. DEPTH must be a power of two (>= 2) so
// the pointers wrap naturally; push while full and pop while empty are
// ignored.
module rlwe_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_LVL);
   assign empty   = (count == '0);
   assign level   = count;
   assign dout    = mem[rd_ptr];

   // Storage write.
   // NOTE: the data array has no reset; occupancy is tracked by count, so
   // stale entries are never observed and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rlwe_part_scheduler.sv
// Scheduler that pops commands from a small FIFO and launches one
// processor-part sub-controller (load, NTT, add/convert) at a time,
// with a post-launch guard window, fixed-length loads, NTT sweeps and a
// run timeout.
module rlwe_part_scheduler
   import rlwe_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GUARD      = 2,
   parameter int LD_CYCLES  = 2048,
   parameter int TIMEOUT    = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [7:0]                    cmd_data,
   input  logic                          part_done,
   output logic                          rst_ld,
   output logic                          rst_nc,
   output logic                          rst_ac,
   output logic [1:0]                    INSTRUCTION_ld,
   output logic [1:0]                    INSTRUCTION_nc,
   output logic [1:0]                    NTT_ITERATION,
   output logic                          add_conv,
   output logic                          modulus_sel,
   output logic                          busy,
   output logic                          err_timeout,
   output logic                          err_illegal,
   input  logic                          err_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam logic [15:0] GUARD_C = 16'(GUARD);
   localparam logic [15:0] LD_LAST = 16'(LD_CYCLES - 1);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   kind_e       kind_q;
   logic        sweep_q;
   logic [1:0]  sweep_cnt_q;
   logic [1:0]  sweep_lim_q;
   logic [15:0] cnt_q;

   logic [CMD_W-1:0] fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   cmd_t             head_cmd;

   logic launch;
   logic illegal_ev;
   logic done_ev;
   logic timeout_ev;
   logic resweep;

   rlwe_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid && cmd_ready),
      .pop   (fifo_pop),
      .din   (cmd_data),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign head_cmd  = cmd_t'(fifo_head);
   assign cmd_ready = !fifo_full;
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;

   // Next-state and event decode.
   // NOTE: every signal written here gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      fifo_pop   = 1'b0;
      launch     = 1'b0;
      illegal_ev = 1'b0;
      done_ev    = 1'b0;
      timeout_ev = 1'b0;
      resweep    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (!is_legal(head_cmd.opcode)) begin
                  illegal_ev = 1'b1;
               end else if (head_cmd.opcode != OP_NOP) begin
                  launch  = 1'b1;
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: state_d = ST_RUN;
         ST_RUN: begin
            if (kind_q == KIND_LD) begin
               done_ev = (cnt_q == LD_LAST);
            end else if (part_done && (cnt_q >= GUARD_C)) begin
               done_ev = 1'b1;
            end else if (cnt_q == TO_LAST) begin
               timeout_ev = 1'b1;
            end
            if (done_ev || timeout_ev) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (sweep_q && (sweep_cnt_q < sweep_lim_q)) begin
               resweep = 1'b1;
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Run enables, run counter, configuration latches, sweep tracking and sticky errors.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_ld         <= 1'b1;
         rst_nc         <= 1'b1;
         rst_ac         <= 1'b1;
         kind_q         <= KIND_LD;
         sweep_q        <= 1'b0;
         sweep_cnt_q    <= 2'd0;
         sweep_lim_q    <= 2'd0;
         cnt_q          <= 16'd0;
         INSTRUCTION_ld <= 2'd0;
         INSTRUCTION_nc <= 2'd0;
         NTT_ITERATION  <= 2'd0;
         add_conv       <= 1'b0;
         modulus_sel    <= 1'b0;
         err_timeout    <= 1'b0;
         err_illegal    <= 1'b0;
      end else begin
         // An enable is low only for cycles spent in RUN for its own kind.
         rst_ld <= !((state_d == ST_RUN) && (kind_q == KIND_LD));
         rst_nc <= !((state_d == ST_RUN) && (kind_q == KIND_NC));
         rst_ac <= !((state_d == ST_RUN) && (kind_q == KIND_AC));

         cnt_q <= (state_q == ST_RUN) ? cnt_q + 16'd1 : 16'd0;

         if (launch) begin
            kind_q      <= kind_of(head_cmd.opcode);
            modulus_sel <= head_cmd.modulus_sel;
            sweep_q     <= 1'b0;
            case (head_cmd.opcode)
               OP_LOAD: INSTRUCTION_ld <= head_cmd.instr;
               OP_NTT: begin
                  INSTRUCTION_nc <= head_cmd.instr;
                  NTT_ITERATION  <= head_cmd.iter;
               end
               OP_SWEEP: begin
                  INSTRUCTION_nc <= head_cmd.instr;
                  NTT_ITERATION  <= 2'd0;
                  sweep_q        <= 1'b1;
                  sweep_cnt_q    <= 2'd0;
                  sweep_lim_q    <= head_cmd.iter;
               end
               OP_ADDCONV0, OP_ADDCONV1: add_conv <= head_cmd.opcode[0];
               default: ;
            endcase
         end

         // A timed-out run abandons whatever is left of its sweep.
         if (timeout_ev) sweep_q <= 1'b0;

         if (resweep) begin
            sweep_cnt_q   <= sweep_cnt_q + 2'd1;
            NTT_ITERATION <= sweep_cnt_q + 2'd1;
         end

         // A new error event wins over a simultaneous clear.
         err_illegal <= (err_illegal && !err_clr) || illegal_ev;
         err_timeout <= (err_timeout && !err_clr) || timeout_ev;
      end
   end

endmodule
